// File: rtl/can_frame_rx.sv
// can_frame_rx: CAN 2.0A standard-frame receiver with destuffing, CRC-15 check and ACK drive
module can_frame_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SAMPLE_PT = 10,
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        can_in,
  output logic        ack_out,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [1:0]  err_code
);
  typedef enum logic [3:0] {INTEG, IDLE, SOF, ID, RTR, IDE, R0, DLC, DATA, CRC, CRCD, ACK, ACKD, EOF} state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(IDLE_BITS + 1);
  state_t state;
  logic [2:0] sy;
  logic [CW-1:0] cnt, cur;
  logic [IW-1:0] icnt;
  logic [2:0] run_len;
  logic run_bit;
  logic [6:0] fc, dlen;
  logic [14:0] crc, rcrc;
  logic [10:0] wid;
  logic wrtr;
  logic [3:0] wdlc, dlc_n;
  logic [63:0] wdata;
  logic bit_v, edge_v, smp, wrap, stf_reg, stuff;
  logic [1:0] err;
  assign bit_v = sy[1];
  assign edge_v = state == IDLE && sy[2] && !sy[1];
  assign cur = edge_v ? '0 : cnt;
  assign smp = cur == CW'(SAMPLE_PT);
  assign wrap = cur == CW'(CLKS_PER_BIT - 1);
  // a run of five still pending after the last CRC bit puts the stuff bit in the delimiter slot
  assign stf_reg = (state inside {ID, RTR, IDE, R0, DLC, DATA, CRC}) || (state == CRCD && run_len == 3'd5);
  assign stuff = stf_reg && run_len == 3'd5;
  assign dlc_n = {wdlc[2:0], bit_v};
  assign err = stuff ? (bit_v == run_bit ? 2'd1 : 2'd0) :
               state == CRCD ? (rcrc != crc ? 2'd2 : bit_v ? 2'd0 : 2'd3) :
               (state == IDE && bit_v) || ((state == ACKD || state == EOF) && !bit_v) ? 2'd3 : 2'd0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      sy <= '1;
      cnt <= '0;
      icnt <= '0;
      state <= INTEG;
      run_len <= '0;
      run_bit <= 1'b0;
      fc <= '0;
      dlen <= '0;
      crc <= '0;
      rcrc <= '0;
      wid <= '0;
      wrtr <= 1'b0;
      wdlc <= '0;
      wdata <= '0;
      ack_out <= 1'b1;
      rx_id <= '0;
      rx_rtr <= 1'b0;
      rx_dlc <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
      err_code <= '0;
    end else begin
      sy <= {sy[1:0], can_in};
      cnt <= wrap ? '0 : cur + 1'b1;
      rx_valid <= 1'b0;
      rx_err <= 1'b0;
      err_code <= 2'd0;
      if (edge_v) state <= SOF;
      if (state == ACK && wrap) ack_out <= 1'b0;
      if (state == ACKD && wrap) ack_out <= 1'b1;
      if (smp && err != 2'd0) begin
        state <= INTEG;
        icnt <= '0;
        rx_err <= 1'b1;
        err_code <= err;
        ack_out <= 1'b1;
      end else if (smp) begin
        if (stuff) begin
          run_bit <= bit_v;
          run_len <= 3'd1;
        end else begin
          if (stf_reg) begin
            run_len <= bit_v == run_bit ? run_len + 3'd1 : 3'd1;
            run_bit <= bit_v;
          end
          if (state inside {SOF, ID, RTR, IDE, R0, DLC, DATA})
            crc <= {crc[13:0], 1'b0} ^ ((bit_v ^ crc[14]) ? 15'h4599 : 15'h0);
          fc <= fc + 7'd1;
          case (state)
            INTEG: begin
              icnt <= bit_v ? icnt + 1'b1 : '0;
              if (bit_v && icnt == IW'(IDLE_BITS - 1)) state <= IDLE;
            end
            SOF: begin
              if (bit_v) state <= IDLE;
              else begin
                state <= ID;
                fc <= '0;
                run_bit <= 1'b0;
                run_len <= 3'd1;
                crc <= '0;
                wdata <= '0;
              end
            end
            ID: begin
              wid <= {wid[9:0], bit_v};
              if (fc == 7'd10) state <= RTR;
            end
            RTR: begin
              wrtr <= bit_v;
              state <= IDE;
            end
            IDE: state <= R0;
            R0: begin
              state <= DLC;
              fc <= '0;
            end
            DLC: begin
              wdlc <= dlc_n;
              if (fc == 7'd3) begin
                fc <= '0;
                dlen <= dlc_n[3] ? 7'd64 : {1'b0, dlc_n[2:0], 3'b000};
                state <= (wrtr || dlc_n == 4'd0) ? CRC : DATA;
              end
            end
            DATA: begin
              wdata[6'd63 - fc[5:0]] <= bit_v;
              if (fc == dlen - 7'd1) begin
                fc <= '0;
                state <= CRC;
              end
            end
            CRC: begin
              rcrc <= {rcrc[13:0], bit_v};
              if (fc == 7'd14) state <= CRCD;
            end
            CRCD: state <= ACK;
            ACK: state <= ACKD;
            ACKD: begin
              state <= EOF;
              fc <= '0;
            end
            EOF: begin
              if (fc == 7'd6) begin
                state <= IDLE;
                rx_valid <= 1'b1;
                rx_id <= wid;
                rx_rtr <= wrtr;
                rx_dlc <= wdlc;
                rx_data <= wdata;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_can_frame_rx.sv
// tb_can_frame_rx: directed frames with a bench-side CRC/stuffing transmitter model
module tb_can_frame_rx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic can_in = 1'b1;
  logic ack_out, rx_rtr, rx_valid, rx_err;
  logic [10:0] rx_id;
  logic [3:0] rx_dlc;
  logic [63:0] rx_data;
  logic [1:0] err_code;
  int checks = 0, errors = 0;
  int n_valid = 0, n_err = 0, n_both = 0, n_ack = 0;
  int v0, e0, a0;
  logic [1:0] last_code = 2'd0;
  can_frame_rx dut (
    .clk(clk), .reset(reset), .can_in(can_in), .ack_out(ack_out), .rx_id(rx_id), .rx_rtr(rx_rtr),
    .rx_dlc(rx_dlc), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (rx_err) begin
      n_err++;
      last_code = err_code;
    end
    if (rx_valid && rx_err) n_both++;
    if (!ack_out) n_ack++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic b);
    can_in = b;
    repeat (16) @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b1);
  endtask
  task automatic snap();
    v0 = n_valid;
    e0 = n_err;
    a0 = n_ack;
  endtask
  task automatic send(input logic [10:0] id, input logic rtr, input logic ide, input logic [3:0] dlc,
                      input logic [63:0] data, input bit flip, input bit crcd_dom, input int rst_at);
    bit raw[$];
    bit s[$];
    logic [14:0] crc;
    bit last;
    int run, nb;
    crc = '0;
    run = 0;
    last = 1'b0;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : (dlc > 4'd8 ? 64 : int'(dlc) * 8);
    for (int i = 0; i < nb; i++) raw.push_back(data[63-i]);
    foreach (raw[i]) crc = {crc[13:0], 1'b0} ^ ((raw[i] ^ crc[14]) ? 15'h4599 : 15'h0);
    if (flip) raw[18+nb] = !raw[18+nb];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    foreach (raw[i]) begin
      s.push_back(raw[i]);
      if (run > 0 && raw[i] == last) run++;
      else begin
        last = raw[i];
        run = 1;
      end
      if (run == 5) begin
        s.push_back(!raw[i]);
        last = !raw[i];
        run = 1;
      end
    end
    s.push_back(!crcd_dom);
    repeat (9) s.push_back(1'b1);
    foreach (s[i]) begin
      if (i == rst_at) begin
        can_in = s[i];
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_ack", ack_out, 1);
        chk("rst_id", rx_id, 0);
        chk("rst_dlc", rx_dlc, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_err", {rx_err, err_code}, 0);
        repeat (10) @(negedge clk);
      end else drive(s[i]);
    end
  endtask
  initial begin
    repeat (4) @(negedge clk);
    chk("reset_ack", ack_out, 1);
    chk("reset_outs", {rx_valid, rx_err, err_code, rx_rtr, rx_dlc, rx_id}, 0);
    chk("reset_data", rx_data, 0);
    reset = 1'b1;
    idle(11);
    snap();
    send(11'h123, 1'b0, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b0, -1);
    chk("f1_valid", n_valid - v0, 1);
    chk("f1_noerr", n_err - e0, 0);
    chk("f1_ack16", n_ack - a0, 16);
    chk("f1_id", rx_id, 11'h123);
    chk("f1_rtr", rx_rtr, 0);
    chk("f1_dlc", rx_dlc, 1);
    chk("f1_data", rx_data, 64'hA500000000000000);
    idle(11);
    snap();
    send(11'h000, 1'b0, 1'b0, 4'd8, 64'h00FF00FF00FF00FF, 1'b0, 1'b0, -1);
    chk("f2_valid", n_valid - v0, 1);
    chk("f2_noerr", n_err - e0, 0);
    chk("f2_id", rx_id, 0);
    chk("f2_dlc", rx_dlc, 8);
    chk("f2_data", rx_data, 64'h00FF00FF00FF00FF);
    idle(11);
    snap();
    send(11'h123, 1'b0, 1'b0, 4'd1, 64'hA5 << 56, 1'b1, 1'b0, -1);
    chk("crc_err", n_err - e0, 1);
    chk("crc_code", last_code, 2);
    chk("crc_novalid", n_valid - v0, 0);
    chk("crc_noack", n_ack - a0, 0);
    chk("crc_keep_dlc", rx_dlc, 8);
    chk("crc_keep_data", rx_data, 64'h00FF00FF00FF00FF);
    idle(11);
    snap();
    repeat (6) drive(1'b0);
    idle(1);
    chk("stuff_err", n_err - e0, 1);
    chk("stuff_code", last_code, 1);
    idle(4);
    snap();
    send(11'h123, 1'b0, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b0, -1);
    chk("short_idle_ignored", {n_valid - v0, n_err - e0}, 0);
    idle(11);
    snap();
    send(11'h123, 1'b0, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b0, -1);
    chk("reinteg_valid", n_valid - v0, 1);
    chk("reinteg_data", rx_data, 64'hA500000000000000);
    idle(11);
    snap();
    send(11'h123, 1'b0, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b1, -1);
    chk("crcd_err", n_err - e0, 1);
    chk("crcd_code", last_code, 3);
    chk("crcd_noack", n_ack - a0, 0);
    idle(11);
    snap();
    send(11'h0F0, 1'b0, 1'b1, 4'd2, 64'h1234 << 48, 1'b0, 1'b0, -1);
    chk("ide_err", n_err - e0, 1);
    chk("ide_code", last_code, 3);
    chk("ide_novalid", n_valid - v0, 0);
    chk("ide_keep_id", rx_id, 11'h123);
    idle(11);
    send(11'h123, 1'b0, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b0, 22);
    snap();
    idle(11);
    chk("rst_frame_novalid", n_valid - v0, 0);
    snap();
    send(11'h000, 1'b0, 1'b0, 4'd8, 64'h00FF00FF00FF00FF, 1'b0, 1'b0, -1);
    chk("post_rst_valid", n_valid - v0, 1);
    chk("post_rst_dlc", rx_dlc, 8);
    chk("post_rst_data", rx_data, 64'h00FF00FF00FF00FF);
    chk("no_overlap", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
